// File: rtl/cpu_controller_if.sv
// Memory bus between the controller and its single-port memory.
//   mem_cmd   : 00 NONE, 01 READ, 10 WRITE (driven by master)
//   mem_addr  : word address (driven by master)
//   read_data : read data, valid the cycle after a READ is presented (driven by slave)
interface cpu_controller_if #(
  parameter int unsigned PC_W = 9,
  parameter int unsigned IW   = 16
);
  logic [1:0]      mem_cmd;
  logic [PC_W-1:0] mem_addr;
  logic [IW-1:0]   read_data;

  modport master (
    output mem_cmd,
    output mem_addr,
    input  read_data
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    output read_data
  );
endinterface

// File: rtl/cpu_controller.sv
// Fetch / decode / control FSM that sits directly upstream of the datapath.
// Owns the PC, the instruction register and the data-address register, and drives
// one datapath micro-step per state.
//   clk, rst_n       : clock, asynchronous active-low reset
//   mem_bus          : memory bus (fetch, LDR read, STR write; write data is datapath_out)
//   readnum_o/writenum_o, write_o, vsel_o : register-file controls
//   loada_o/loadb_o/loadc_o/loads_o, asel_o, bsel_o, shift_o, alu_op_o : datapath controls
//   sximm8_o, sximm5_o : sign-extended immediates from IR
//   mdata_o          : memory read data passed to the datapath
//   pc_o             : current PC
//   datapath_out_i   : datapath C register, low bits load the data-address register
//   halted_o         : high while in HALT
module cpu_controller #(
  parameter int unsigned PC_W = 9,
  parameter int unsigned IW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cpu_controller_if.master       mem_bus,
  output logic [2:0]             readnum_o,
  output logic [2:0]             writenum_o,
  output logic                   write_o,
  output logic [1:0]             vsel_o,
  output logic                   loada_o,
  output logic                   loadb_o,
  output logic                   loadc_o,
  output logic                   loads_o,
  output logic                   asel_o,
  output logic                   bsel_o,
  output logic [1:0]             shift_o,
  output logic [1:0]             alu_op_o,
  output logic [IW-1:0]          sximm8_o,
  output logic [IW-1:0]          sximm5_o,
  output logic [IW-1:0]          mdata_o,
  output logic [PC_W-1:0]        pc_o,
  input  logic [IW-1:0]          datapath_out_i,
  output logic                   halted_o
);

  typedef enum logic [4:0] {
    StRst, StIf1, StIf2, StUpc, StDec,
    StWimm, StGeta, StGetb, StPass, StExec, StWrd,
    StAddr, StLda, StMrd, StLwb,
    StSgb, StSps, StSwr,
    StHalt
  } state_e;

  localparam logic [1:0] CmdNone  = 2'b00;
  localparam logic [1:0] CmdRead  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [IW-1:0]   ir_q;
  logic [PC_W-1:0] dar_q;

  logic       load_pc, reset_pc, load_ir, load_addr, addr_sel;
  logic [2:0] nsel;

  // Instruction fields
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  // Only the address-sized slice of the datapath result is needed here.
  logic unused_dp_hi;
  assign unused_dp_hi = ^datapath_out_i[IW-1:PC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRst;
      pc_q    <= '0;
      ir_q    <= '0;
      dar_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_pc)   pc_q  <= reset_pc ? '0 : pc_q + PC_W'(1);
      if (load_ir)   ir_q  <= mem_bus.read_data;
      if (load_addr) dar_q <= datapath_out_i[PC_W-1:0];
    end
  end

  always_comb begin
    state_d         = state_q;
    load_pc         = 1'b0;
    reset_pc        = 1'b0;
    load_ir         = 1'b0;
    load_addr       = 1'b0;
    addr_sel        = 1'b0;
    nsel            = 3'd0;
    mem_bus.mem_cmd = CmdNone;
    write_o         = 1'b0;
    vsel_o          = 2'd0;
    loada_o         = 1'b0;
    loadb_o         = 1'b0;
    loadc_o         = 1'b0;
    loads_o         = 1'b0;
    asel_o          = 1'b0;
    bsel_o          = 1'b0;
    shift_o         = 2'b00;
    alu_op_o        = 2'b00;
    halted_o        = 1'b0;

    case (state_q)
      StRst: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        state_d  = StIf1;
      end
      StIf1: begin
        addr_sel        = 1'b1;
        mem_bus.mem_cmd = CmdRead;
        state_d         = StIf2;
      end
      StIf2: begin
        addr_sel        = 1'b1;
        mem_bus.mem_cmd = CmdRead;
        load_ir         = 1'b1;
        state_d         = StUpc;
      end
      StUpc: begin
        load_pc = 1'b1;
        state_d = StDec;
      end
      StDec: begin
        // Any encoding not matched below executes as a NOP.
        case (opcode)
          3'b110: begin
            if (op == 2'b10)      state_d = StWimm;
            else if (op == 2'b00) state_d = StGetb;
            else                  state_d = StIf1;
          end
          3'b101:  state_d = (op == 2'b11) ? StGetb : StGeta;  // MVN has no A operand
          3'b011:  state_d = (op == 2'b00) ? StGeta : StIf1;
          3'b100:  state_d = (op == 2'b00) ? StGeta : StIf1;
          3'b111:  state_d = StHalt;
          default: state_d = StIf1;
        endcase
      end
      StWimm: begin
        nsel    = rn;
        vsel_o  = 2'd2;
        write_o = 1'b1;
        state_d = StIf1;
      end
      StGeta: begin
        nsel    = rn;
        loada_o = 1'b1;
        state_d = (opcode == 3'b101) ? StGetb : StAddr;
      end
      StGetb: begin
        nsel    = rm;
        loadb_o = 1'b1;
        state_d = (opcode == 3'b110) ? StPass : StExec;
      end
      StPass: begin
        asel_o  = 1'b1;
        shift_o = sh;
        loadc_o = 1'b1;
        state_d = StWrd;
      end
      StExec: begin
        alu_op_o = op;
        shift_o  = sh;
        loadc_o  = 1'b1;
        loads_o  = (op == 2'b01);
        // CMP only updates status, nothing to write back.
        state_d  = (op == 2'b01) ? StIf1 : StWrd;
      end
      StWrd: begin
        nsel    = rd;
        vsel_o  = 2'd0;
        write_o = 1'b1;
        state_d = StIf1;
      end
      StAddr: begin
        bsel_o  = 1'b1;
        loadc_o = 1'b1;
        state_d = StLda;
      end
      StLda: begin
        load_addr = 1'b1;
        state_d   = (opcode == 3'b011) ? StMrd : StSgb;
      end
      StMrd: begin
        mem_bus.mem_cmd = CmdRead;
        state_d         = StLwb;
      end
      StLwb: begin
        mem_bus.mem_cmd = CmdRead;
        nsel            = rd;
        vsel_o          = 2'd3;
        write_o         = 1'b1;
        state_d         = StIf1;
      end
      StSgb: begin
        nsel    = rd;
        loadb_o = 1'b1;
        state_d = StSps;
      end
      StSps: begin
        // Pass Rd through unshifted so datapath_out carries the store data.
        asel_o  = 1'b1;
        loadc_o = 1'b1;
        state_d = StSwr;
      end
      StSwr: begin
        mem_bus.mem_cmd = CmdWrite;
        state_d         = StIf1;
      end
      StHalt: begin
        halted_o = 1'b1;
      end
      default: state_d = StRst;
    endcase
  end

  assign mem_bus.mem_addr = addr_sel ? pc_q : dar_q;
  assign readnum_o        = nsel;
  assign writenum_o       = nsel;
  assign sximm8_o         = {{(IW-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5_o         = {{(IW-5){ir_q[4]}}, ir_q[4:0]};
  assign mdata_o          = mem_bus.read_data;
  assign pc_o             = pc_q;

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel, halted;
  logic [1:0]  vsel, shift, alu_op;
  logic [15:0] sximm8, sximm5, mdata, datapath_out;
  logic [8:0]  pc;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [512];

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_bus        (bus),
    .readnum_o      (readnum),
    .writenum_o     (writenum),
    .write_o        (write),
    .vsel_o         (vsel),
    .loada_o        (loada),
    .loadb_o        (loadb),
    .loadc_o        (loadc),
    .loads_o        (loads),
    .asel_o         (asel),
    .bsel_o         (bsel),
    .shift_o        (shift),
    .alu_op_o       (alu_op),
    .sximm8_o       (sximm8),
    .sximm5_o       (sximm5),
    .mdata_o        (mdata),
    .pc_o           (pc),
    .datapath_out_i (datapath_out),
    .halted_o       (halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; writes are observed but not stored so the program stays intact.
  always @(posedge clk) begin
    if (bus.mem_cmd == 2'b01) bus.read_data <= mem[bus.mem_addr];
  end

  // Per-instruction summary of what the controller did over one instruction window.
  typedef struct packed {
    logic [5:0]  fetch;
    logic [8:0]  f_addr;
    logic [3:0]  n_loada;
    logic [2:0]  a_idx;
    logic [3:0]  n_loadb;
    logic [2:0]  b_idx;
    logic [3:0]  n_loadc;
    logic [3:0]  n_loads;
    logic [3:0]  n_write;
    logic [2:0]  w_idx;
    logic [1:0]  w_vsel;
    logic [1:0]  c_alu;
    logic [1:0]  c_sh;
    logic        c_asel;
    logic        c_bsel;
    logic [3:0]  n_rd;
    logic [8:0]  rd_addr;
    logic [3:0]  n_wr;
    logic [8:0]  wr_addr;
    logic [8:0]  pc_dec;
    logic [15:0] sx8;
    logic [15:0] sx5;
    logic [3:0]  n_halt;
    logic [3:0]  n_bad;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    logic [8:0]  dpo;
    int          len;
    logic [3:0]  na;
    logic [2:0]  aidx;
    logic [3:0]  nb;
    logic [2:0]  bidx;
    logic [3:0]  nw;
    logic [2:0]  widx;
    logic [1:0]  vsel;
    logic [1:0]  alu;
    logic [1:0]  sh;
    logic [3:0]  nloads;
    logic [3:0]  nrd;
    logic [3:0]  nwr;
    logic [8:0]  maddr;
    logic [15:0] sx8;
    logic [15:0] sx5;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_window(input int len, output obs_t o);
    logic [5:0] f;
    o = '0;
    f = '0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i < 3) f = {f[3:0], bus.mem_cmd};
      if (i == 0) o.f_addr = bus.mem_addr;
      if (i == 3) begin
        o.pc_dec = pc;
        o.sx8    = sximm8;
        o.sx5    = sximm5;
      end
      if (loada) begin o.n_loada = o.n_loada + 4'd1; o.a_idx = readnum; end
      if (loadb) begin o.n_loadb = o.n_loadb + 4'd1; o.b_idx = readnum; end
      if (loadc) begin
        o.n_loadc = o.n_loadc + 4'd1;
        o.c_alu   = alu_op;
        o.c_sh    = shift;
        o.c_asel  = asel;
        o.c_bsel  = bsel;
      end
      if (loads) o.n_loads = o.n_loads + 4'd1;
      if (write) begin o.n_write = o.n_write + 4'd1; o.w_idx = writenum; o.w_vsel = vsel; end
      if (i >= 3 && bus.mem_cmd == 2'b01) begin o.n_rd = o.n_rd + 4'd1; o.rd_addr = bus.mem_addr; end
      if (bus.mem_cmd == 2'b10) begin o.n_wr = o.n_wr + 4'd1; o.wr_addr = bus.mem_addr; end
      if (halted) o.n_halt = o.n_halt + 4'd1;
      if ((writenum != readnum) || (mdata !== bus.read_data)) o.n_bad = o.n_bad + 4'd1;
    end
    o.fetch = f;
  endtask

  // Reference: what one instruction should do, from the instruction set rules.
  task automatic model(input logic [15:0] ins, input logic [8:0] ipc, input logic [8:0] dpo,
                       output obs_t e, output int len);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8]; rd = ins[7:5]; sh = ins[4:3];
    rm = ins[2:0];
    e        = '0;
    e.fetch  = 6'b01_01_00;
    e.f_addr = ipc;
    e.pc_dec = ipc + 9'd1;
    e.sx8    = {{8{ins[7]}}, ins[7:0]};
    e.sx5    = {{11{ins[4]}}, ins[4:0]};
    len      = 4;
    if (opc == 3'b110 && op == 2'b10) begin
      len = 5;
      e.n_write = 1; e.w_idx = rn; e.w_vsel = 2;
    end else if (opc == 3'b110 && op == 2'b00) begin
      len = 7;
      e.n_loadb = 1; e.b_idx = rm;
      e.n_loadc = 1; e.c_sh = sh; e.c_asel = 1'b1;
      e.n_write = 1; e.w_idx = rd; e.w_vsel = 0;
    end else if (opc == 3'b101) begin
      if (op != 2'b11) begin e.n_loada = 1; e.a_idx = rn; end
      e.n_loadb = 1; e.b_idx = rm;
      e.n_loadc = 1; e.c_alu = op; e.c_sh = sh;
      if (op == 2'b01) begin
        len = 7; e.n_loads = 1;
      end else begin
        len = (op == 2'b11) ? 7 : 8;
        e.n_write = 1; e.w_idx = rd; e.w_vsel = 0;
      end
    end else if (opc == 3'b011 && op == 2'b00) begin
      len = 9;
      e.n_loada = 1; e.a_idx = rn;
      e.n_loadc = 1; e.c_bsel = 1'b1;
      e.n_rd = 2; e.rd_addr = dpo;
      e.n_write = 1; e.w_idx = rd; e.w_vsel = 3;
    end else if (opc == 3'b100 && op == 2'b00) begin
      len = 10;
      e.n_loada = 1; e.a_idx = rn;
      e.n_loadb = 1; e.b_idx = rd;
      e.n_loadc = 2; e.c_asel = 1'b1;
      e.n_wr = 1; e.wr_addr = dpo;
    end
  endtask

  function automatic logic [15:0] rand_ins();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 8))
      0:       r[15:11] = 5'b11010;
      1:       r[15:11] = 5'b11000;
      2:       r[15:11] = 5'b10100;
      3:       r[15:11] = 5'b10101;
      4:       r[15:11] = 5'b10110;
      5:       r[15:11] = 5'b10111;
      6:       r[15:11] = 5'b01100;
      7:       r[15:11] = 5'b10000;
      default: r[15:13] = 3'($urandom_range(0, 2));
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t        o, e;
    int          len, cnt;
    logic [8:0]  pcm, dpo;
    logic [15:0] ins;

    //             ins      dpo    len na a  nb b  nw w  v  alu sh nl rd wr maddr  sx8       sx5
    vecs[0] = '{16'hD007, 9'h000, 5, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 9'h000, 16'h0007, 16'h0007};
    vecs[1] = '{16'hD1FE, 9'h000, 5, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 9'h000, 16'hFFFE, 16'hFFFE};
    vecs[2] = '{16'hA049, 9'h000, 8, 1, 0, 1, 1, 1, 2, 0, 0, 1, 0, 0, 0, 9'h000, 16'h0049, 16'h0009};
    vecs[3] = '{16'h6061, 9'h005, 9, 1, 0, 0, 0, 1, 3, 3, 0, 0, 0, 2, 0, 9'h005, 16'h0061, 16'h0001};
    vecs[4] = '{16'h8061, 9'h1A3, 10, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 9'h1A3, 16'h0061, 16'h0001};
    vecs[5] = '{16'hA8A8, 9'h000, 7, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 9'h000, 16'hFFA8, 16'h0008};
    vecs[6] = '{16'hB853, 9'h000, 7, 0, 0, 1, 3, 1, 2, 0, 3, 2, 0, 0, 0, 9'h000, 16'h0053, 16'hFFF3};
    vecs[7] = '{16'h2345, 9'h000, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h000, 16'h0045, 16'h0005};

    datapath_out = '0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = vecs[i].ins;

    // Reset state
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cmd", 128'(bus.mem_cmd), 128'(0));
    chk("reset_pc", 128'(pc), 128'(0));
    chk("reset_halted", 128'(halted), 128'(0));
    chk("reset_ctrl", 128'({write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, alu_op,
                            readnum, writenum}), 128'(0));
    chk("reset_imm", 128'({sximm8, sximm5}), 128'(0));
    chk("reset_addr", 128'(bus.mem_addr), 128'(0));
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      datapath_out = {7'd0, vecs[i].dpo};
      run_window(vecs[i].len, o);
      chk($sformatf("v%0d_fetch", i), 128'({o.fetch, o.f_addr}), 128'({6'b010100, 9'(i)}));
      chk($sformatf("v%0d_regs", i), 128'({o.n_loada, o.a_idx, o.n_loadb, o.b_idx}),
          128'({vecs[i].na, vecs[i].aidx, vecs[i].nb, vecs[i].bidx}));
      chk($sformatf("v%0d_write", i), 128'({o.n_write, o.w_idx, o.w_vsel}),
          128'({vecs[i].nw, vecs[i].widx, vecs[i].vsel}));
      chk($sformatf("v%0d_alu", i), 128'({o.c_alu, o.c_sh, o.n_loads}),
          128'({vecs[i].alu, vecs[i].sh, vecs[i].nloads}));
      chk($sformatf("v%0d_mem", i), 128'({o.n_rd, o.rd_addr, o.n_wr, o.wr_addr}),
          128'({vecs[i].nrd, (vecs[i].nrd != 0) ? vecs[i].maddr : 9'd0,
                vecs[i].nwr, (vecs[i].nwr != 0) ? vecs[i].maddr : 9'd0}));
      chk($sformatf("v%0d_imm", i), 128'({o.sx8, o.sx5}), 128'({vecs[i].sx8, vecs[i].sx5}));
      chk($sformatf("v%0d_pc", i), 128'(o.pc_dec), 128'(9'(i + 1)));
      chk($sformatf("v%0d_bad", i), 128'({o.n_halt, o.n_bad}), 128'(0));
    end
    run_window(3, o);
    chk("tail_fetch", 128'({o.fetch, o.f_addr}), 128'({6'b010100, 9'd8}));

    // STR aborted by reset in SGB: no write may reach the bus
    mem[0] = 16'h8061;
    do_reset();
    datapath_out = 16'h00A7;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_cmd == 2'b10) cnt++;
    end
    chk("str_sgb", 128'({loadb, readnum}), 128'({1'b1, 3'd3}));
    rst_n = 1'b0;
    #1;
    chk("str_abort_imm", 128'({bus.mem_cmd, pc, halted}), 128'(0));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.mem_cmd == 2'b10) cnt++;
    end
    chk("str_abort_nowrite", 128'(cnt), 128'(0));
    rst_n = 1'b1;
    run_window(10, o);
    chk("str_full_write", 128'({o.n_wr, o.wr_addr}), 128'({4'd1, 9'h0A7}));

    // HALT holds with the PC frozen
    mem[0] = 16'hE000;
    do_reset();
    run_window(4, o);
    chk("halt_fetch", 128'({o.fetch, o.pc_dec}), 128'({6'b010100, 9'd1}));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted && pc == 9'd1 && bus.mem_cmd == 2'b00 && !write && !loadc) cnt++;
    end
    chk("halt_hold", 128'(cnt), 128'(20));

    // Random program over all of memory, long enough to wrap the PC
    for (int i = 0; i < 512; i++) mem[i] = rand_ins();
    do_reset();
    pcm = '0;
    for (int k = 0; k < 530; k++) begin
      ins = mem[pcm];
      dpo = 9'($urandom);
      datapath_out = {7'($urandom), dpo};
      model(ins, pcm, dpo, e, len);
      run_window(len, o);
      chk($sformatf("rand%0d_%h", k, ins), {1'b0, o}, {1'b0, e});
      if (pcm == 9'd511) chk("pc_wrap", 128'(o.pc_dec), 128'(0));
      pcm = pcm + 9'd1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
